// File: rtl/ram_pkg.sv
// Shared types and elaboration helpers for the clearable dual-port RAM.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } ram_state_t;

  // Number of write-enable lanes in a word.
  function automatic int lanes(input int word, input int lane);
    return word / lane;
  endfunction

  // Legal when lanes tile the word exactly and the array fits the address space.
  function automatic bit params_ok(input int addr_size, input int word,
                                   input int lane, input int mem);
    return (lane > 0) && (word > 0) && (word % lane == 0) &&
           (mem > 0) && (mem <= (1 << addr_size));
  endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Zero-fill sequencer: walks every word once after reset or on request.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_SIZE   = 4,
  parameter int MEMORY_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cs,
  input  logic                 clr,
  output logic                 busy,
  output logic                 clr_done,
  output logic [ADDR_SIZE-1:0] clr_addr,
  output logic                 clr_we
);

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEMORY_SIZE - 1);

  ram_state_t           state_reg, state_next;
  logic [ADDR_SIZE-1:0] clr_ptr_reg, clr_ptr_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= CLEAR;
      clr_ptr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    busy         = 1'b0;
    clr_done     = 1'b0;
    clr_we       = 1'b0;
    case (state_reg)
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (clr_ptr_reg == LAST_ADDR) begin
          clr_done     = 1'b1;
          state_next   = IDLE;
          clr_ptr_next = '0;
        end else begin
          clr_ptr_next = clr_ptr_reg + 1'b1;
        end
      end
      IDLE: begin
        if (cs && clr) begin
          state_next   = CLEAR;
          clr_ptr_next = '0;
        end
      end
      default: begin
        state_next   = CLEAR;
        clr_ptr_next = '0;
      end
    endcase
  end

  assign clr_addr = clr_ptr_reg;

endmodule

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM with lane write enables, write-first read bypass,
// out-of-range flagging and a hardware zero-fill engine.
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int ADDR_SIZE   = 4,
  parameter int WORD_SIZE   = 8,
  parameter int LANE_SIZE   = 4,
  parameter int MEMORY_SIZE = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cs,
  input  logic                           wr,
  input  logic [ADDR_SIZE-1:0]           wr_addr,
  input  logic [WORD_SIZE/LANE_SIZE-1:0] wr_be,
  input  logic [WORD_SIZE-1:0]           data_in,
  input  logic                           rd,
  input  logic [ADDR_SIZE-1:0]           rd_addr,
  output logic [WORD_SIZE-1:0]           data_out,
  output logic                           rd_valid,
  output logic                           rd_err,
  input  logic                           clr,
  output logic                           busy,
  output logic                           clr_done
);

  localparam int LANES = lanes(WORD_SIZE, LANE_SIZE);
  localparam logic [ADDR_SIZE:0] MEM_LIMIT = (ADDR_SIZE + 1)'(MEMORY_SIZE);

  if (!params_ok(ADDR_SIZE, WORD_SIZE, LANE_SIZE, MEMORY_SIZE)) begin : g_param_err
    $error("ram_dp_clr: illegal ADDR_SIZE/WORD_SIZE/LANE_SIZE/MEMORY_SIZE combination");
  end

  logic [ADDR_SIZE-1:0] clr_addr;
  logic                 clr_we;

  ram_clear_ctrl #(
    .ADDR_SIZE  (ADDR_SIZE),
    .MEMORY_SIZE(MEMORY_SIZE)
  ) u_clear_ctrl (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .clr     (clr),
    .busy    (busy),
    .clr_done(clr_done),
    .clr_addr(clr_addr),
    .clr_we  (clr_we)
  );

  logic wr_in_range, rd_in_range, take_wr, take_rd;

  assign wr_in_range = {1'b0, wr_addr} < MEM_LIMIT;
  assign rd_in_range = {1'b0, rd_addr} < MEM_LIMIT;
  // clr in the same cycle pre-empts both user ports.
  assign take_wr = !busy && cs && wr && !clr && wr_in_range;
  assign take_rd = !busy && cs && rd && !clr;

  logic [WORD_SIZE-1:0] mem [MEMORY_SIZE];
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [LANES-1:0]     mem_be;
  logic [WORD_SIZE-1:0] mem_data;

  always_comb begin
    mem_addr = wr_addr;
    mem_be   = '0;
    mem_data = data_in;
    if (clr_we) begin
      mem_addr = clr_addr;
      mem_be   = '1;
      mem_data = '0;
    end else if (take_wr) begin
      mem_be = wr_be;
    end
  end

  // The array has no reset; its contents are defined by the clear engine.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (mem_be[i]) begin
        mem[mem_addr][i*LANE_SIZE +: LANE_SIZE] <= mem_data[i*LANE_SIZE +: LANE_SIZE];
      end
    end
  end

  logic [WORD_SIZE-1:0] rd_word, rd_merged;
  logic                 same_addr;

  assign rd_word   = mem[rd_addr];
  assign same_addr = take_wr && (wr_addr == rd_addr);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_bypass
    assign rd_merged[gi*LANE_SIZE +: LANE_SIZE] =
      (same_addr && wr_be[gi]) ? data_in[gi*LANE_SIZE +: LANE_SIZE]
                               : rd_word[gi*LANE_SIZE +: LANE_SIZE];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= take_rd;
      rd_err   <= take_rd && !rd_in_range;
      if (take_rd) begin
        data_out <= rd_in_range ? rd_merged : '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_dp_clr.sv
// Scoreboard bench for ram_dp_clr: directed cases from the test plan plus random traffic.
module tb_ram_dp_clr;

  localparam int AW = 4;
  localparam int WW = 8;
  localparam int LW = 4;
  localparam int LN = WW / LW;
  localparam int MS = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs = 1'b0, wr = 1'b0, rd = 1'b0, clr = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [LN-1:0] wr_be = '0;
  logic [WW-1:0] data_in = '0;
  logic [WW-1:0] data_out;
  logic          rd_valid, rd_err, busy, clr_done;

  ram_dp_clr #(
    .ADDR_SIZE(AW), .WORD_SIZE(WW), .LANE_SIZE(LW), .MEMORY_SIZE(MS)
  ) dut (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .wr_addr(wr_addr), .wr_be(wr_be),
    .data_in(data_in), .rd(rd), .rd_addr(rd_addr), .data_out(data_out),
    .rd_valid(rd_valid), .rd_err(rd_err), .clr(clr), .busy(busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [WW-1:0] data;
    logic        err;
  } exp_t;

  exp_t          sb[$];
  logic [WW-1:0] model[16];
  int            clear_left = MS;   // busy cycles remaining, counting the current one
  int            cyc = 0;
  int            compared = 0;
  int            mismatched = 0;
  logic [WW-1:0] last_dout = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: per-cycle status checks and scoreboard pops on rd_valid.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_clr_done", 32'(clr_done), 32'd0);
      last_dout = '0;
    end else begin
      check("busy", 32'(busy), 32'(clear_left != 0));
      check("clr_done", 32'(clr_done), 32'(clear_left == 1));
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        check("rd_valid", 32'(rd_valid), 32'd1);
        check("data_out", 32'(data_out), 32'(e.data));
        check("rd_err", 32'(rd_err), 32'(e.err));
        last_dout = e.data;
        $display("read result cycle %0d: data_out=0x%02h rd_err=%0d (expected 0x%02h/%0d)",
                 cyc, data_out, rd_err, e.data, e.err);
      end else begin
        check("no_rd_valid", 32'(rd_valid), 32'd0);
        check("data_out_hold", 32'(data_out), 32'(last_dout));
      end
    end
  end

  // Drive one cycle of inputs and update the reference model for that cycle.
  task automatic step(input logic c, input logic w, input logic r, input logic cl,
                      input logic [AW-1:0] wa, input logic [LN-1:0] be,
                      input logic [WW-1:0] di, input logic [AW-1:0] ra);
    int            nl;
    logic [WW-1:0] v;
    cs = c; wr = w; rd = r; clr = cl;
    wr_addr = wa; wr_be = be; data_in = di; rd_addr = ra;
    nl = 0;
    if (clear_left == 0) begin
      if (c && cl) begin
        for (int i = 0; i < 16; i++) model[i] = '0;
        nl = MS;
      end else if (c) begin
        if (r) begin
          if (int'(ra) < MS) begin
            v = model[ra];
            if (w && wa == ra)
              for (int l = 0; l < LN; l++)
                if (be[l]) v[l*LW +: LW] = di[l*LW +: LW];
            sb.push_back('{cyc + 1, v, 1'b0});
          end else begin
            sb.push_back('{cyc + 1, '0, 1'b1});
          end
        end
        if (w && int'(wa) < MS)
          for (int l = 0; l < LN; l++)
            if (be[l]) model[wa][l*LW +: LW] = di[l*LW +: LW];
      end
    end else begin
      nl = clear_left - 1;
    end
    @(posedge clk);
    #1;
    clear_left = nl;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic rd_step(input logic [AW-1:0] a);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, '0, a);
  endtask

  task automatic wr_step(input logic [AW-1:0] a, input logic [LN-1:0] be, input logic [WW-1:0] d);
    step(1'b1, 1'b1, 1'b0, 1'b0, a, be, d, '0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cs = 1'b0; wr = 1'b0; rd = 1'b0; clr = 1'b0;
    sb.delete();
    clear_left = MS;
    for (int i = 0; i < 16; i++) model[i] = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (clear_left != 0 && k < 4 * MS) begin
      idle_step();
      k++;
    end
  endtask

  initial begin
    do_reset(3);
    wait_idle();
    idle_step();
    for (int a = 0; a < 16; a++) rd_step(AW'(a));
    idle_step();

    // Lane writes
    wr_step(4'd3, 2'b11, 8'hA5);
    wr_step(4'd3, 2'b01, 8'h3C);
    rd_step(4'd3);
    idle_step();

    // Write-first bypass
    wr_step(4'd7, 2'b11, 8'h12);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 2'b10, 8'hF0, 4'd7);
    idle_step();

    // Out of range
    rd_step(4'd13);
    wr_step(4'd13, 2'b11, 8'hFF);
    for (int a = 0; a < MS; a++) rd_step(AW'(a));
    idle_step();

    // clr precedence, then a write while busy
    wr_step(4'd4, 2'b11, 8'h66);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 2'b11, 8'h55, 4'd2);
    wr_step(4'd4, 2'b11, 8'h77);
    wait_idle();
    rd_step(4'd2);
    rd_step(4'd4);
    idle_step();

    // Reset five cycles into a clear
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0, '0, '0);
    repeat (5) idle_step();
    do_reset(2);
    wait_idle();
    for (int a = 0; a < MS; a++) rd_step(AW'(a));
    idle_step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] wa, ra;
      wa = AW'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 15));
      step($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom),
           $urandom_range(0, 49) == 0, wa, LN'($urandom), WW'($urandom), ra);
    end
    idle_step();
    wait_idle();
    repeat (3) idle_step();

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ram_dp_clr.md
# ram_dp_clr

Parametrised successor to the team's single-port RAM. It provides:
- a synchronous simple-dual-port memory (one write port, one read port), one clock;
- per-lane write enables and a registered read with write-first bypass;
- out-of-range detection;
- a hardware clear engine that zero-fills the array after reset or on request.

It sits between the datapath and any block that previously instantiated the combinational `ram`.

## Interface
Parameters:
- `ADDR_SIZE`, 4: address width. `MEMORY_SIZE` must be ≤ 2**`ADDR_SIZE`.
- `WORD_SIZE`, 8: data word width.
- `LANE_SIZE`, 4: write-enable lane width. `WORD_SIZE` must be a multiple of `LANE_SIZE`. `LANES` = `WORD_SIZE`/`LANE_SIZE`.
- `MEMORY_SIZE`, 16: number of words.

Ports:
- `clk`  in  1  sole clock. Rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cs`  in  1  chip select. When low, `wr`, `rd` and `clr` are ignored.
- `wr`  in  1  write request.
- `wr_addr`  in  `ADDR_SIZE`  write address.
- `wr_be`  in  `LANES`  lane enables. Bit i covers `data_in[i*LANE_SIZE +: LANE_SIZE]`.
- `data_in`  in  `WORD_SIZE`  write data.
- `rd`  in  1  read request.
- `rd_addr`  in  `ADDR_SIZE`  read address.
- `data_out`  out  `WORD_SIZE`  registered read data.
- `rd_valid`  out  1  one-cycle pulse: `data_out` is updated this cycle.
- `rd_err`  out  1  qualifies `rd_valid`: the read address was out of range.
- `clr`  in  1  request a zero-fill of the whole array.
- `busy`  out  1  clear engine active. All requests are ignored while high.
- `clr_done`  out  1  one-cycle pulse on the last clear write.

## Operation
- **FSM states:** CLEAR, IDLE.
  - Async reset forces CLEAR with `clr_ptr`=0.
  - CLEAR writes 0 to `mem[clr_ptr]` each cycle and increments `clr_ptr`.
  - On `clr_ptr`==`MEMORY_SIZE`-1: write, pulse `clr_done`, go to IDLE.
  - IDLE: `cs && clr` → CLEAR with `clr_ptr`=0.
- **busy:** `busy`=1 exactly while in CLEAR.
- **Writes:** taken in IDLE when `cs && wr && !clr` and `wr_addr` < `MEMORY_SIZE`.
  - Only lanes with `wr_be`=1 are updated. `wr_be`=0 is a no-op.
  - An out-of-range write is silently dropped.
- **Reads:** taken in IDLE when `cs && rd && !clr`.
  - In range: next cycle `data_out`=`mem[rd_addr]`, `rd_valid`=1, `rd_err`=0.
  - Out of range: next cycle `data_out`=0, `rd_valid`=1, `rd_err`=1.
- **Read-during-write, same address, same cycle:** write-first.
  - Enabled lanes return the new `data_in`; disabled lanes return the old contents.
- **clr precedence:** `clr` wins over `wr` and `rd` in the same cycle. The write is dropped and no `rd_valid` is produced.
- **Ignored requests:** `clr`, `wr` and `rd` are ignored while `busy`. There is no queueing and no error flag.
- **Memory contents:** the array itself is not reset by `rst`. Contents are defined only after the first `clr_done`.

## Timing
- **Reset values:**
  - `data_out`=0, `rd_valid`=0, `rd_err`=0.
  - `busy`=1 asynchronously on `rst` assertion.
  - `clr_done`=0.
- **Post-reset clear:** `busy` stays high for `MEMORY_SIZE` cycles after `rst` deasserts. The first IDLE cycle is cycle `MEMORY_SIZE`+1.
- **Read latency:** 1 cycle, request edge to `data_out`/`rd_valid`.
- **data_out hold:** `data_out` holds its value when no read is taken.
- **Back-to-back reads:** one result per cycle.
- **Write latency:** written data is visible to a read issued in the next cycle. In the same cycle it is visible via the bypass.
- **clr latency:** `clr` taken at cycle N gives `busy`=1 from N+1 through N+`MEMORY_SIZE`, with `clr_done` at N+`MEMORY_SIZE`.
- **Reset during CLEAR:** aborts the clear. On release the clear restarts at address 0, and no `clr_done` is emitted for the aborted pass.
- **Reset in flight:** a reset in the cycle after a read suppresses that read's `rd_valid`.

## Structure
- **Package `ram_pkg`:**
  - state enum `ram_state_t` {CLEAR, IDLE};
  - function `lanes(word, lane)`;
  - parameter legality checks (elaboration-time asserts: divisibility, `MEMORY_SIZE` ≤ 2**`ADDR_SIZE`).
- **Sub-module `ram_clear_ctrl`:**
  - contains the FSM and `clr_ptr`;
  - outputs `busy`, `clr_done`, clear address and clear write-enable.
- **Top level:**
  - muxes the clear and user write;
  - holds the array, lane merge, bypass and read register.

## Test plan
- **Reset and clear:** release `rst` and read every address after `clr_done` → `busy` is high for exactly 16 cycles, `clr_done` pulses once, and all reads return 0x00 with `rd_err`=0.
- **Lane writes:** write 0xA5 to addr 3 with `wr_be`=2'b11, then write 0x3C with `wr_be`=2'b01, then read addr 3 → 0xAC one cycle after `rd`.
- **Write-first bypass:** same-cycle `wr` of 0xF0 (`wr_be`=2'b10) and `rd` to addr 7, which holds 0x12 → `data_out`=0xF2 next cycle.
- **Out of range:** with `MEMORY_SIZE`=12, read addr 13 → `rd_valid`=1, `rd_err`=1, `data_out`=0. A write to addr 13 leaves addresses 0–11 unchanged.
- **clr precedence:** `clr`, `wr` (addr 2, 0x55) and `rd` in the same cycle → no `rd_valid`, `busy` from the next cycle, and after `clr_done` addr 2 reads 0x00. A `wr` issued while `busy` has no effect.
- **Reset mid-clear:** assert `rst` 5 cycles into a clear → no `clr_done`. After release a full 16-cycle clear runs and ends with one `clr_done`.
